// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arb_mux arbitrated multiplexer.
package arb_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_rr_grant.sv
// Rotating priority encoder: one-hot grant to the first requester at or after base.
module arb_rr_grant #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  base,
  output logic [NUM_IN-1:0] grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(base) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-input arbitrated multiplexer with a single registered output beat,
// fixed-priority or round-robin selection and a forced-channel override.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int MODE   = 1,
  localparam int SEL_W = (clog2(NUM_IN) > 1) ? clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]  data_p0;
  logic [SEL_W-1:0]  sel_p0;
  logic              vld_p0;
  logic [SEL_W-1:0]  ptr;

  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  base;
  logic [SEL_W-1:0]  gidx;
  logic              load_ok;
  logic              xfer;

  // Forcing narrows the request set to one channel; out-of-range indices request nothing.
  always_comb begin
    req = '0;
    if (force_en) begin
      if (int'(force_sel) < NUM_IN) req[force_sel] = in_valid[force_sel];
    end else begin
      req = in_valid;
    end
  end

  assign base = (MODE == MODE_RR) ? ptr : '0;

  arb_rr_grant #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_grant (
    .req   (req),
    .base  (base),
    .grant (grant)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) gidx = SEL_W'(i);
    end
  end

  assign load_ok  = !vld_p0 || out_ready;
  assign in_ready = (load_ok && rst_n) ? grant : '0;
  assign xfer     = |(in_ready & in_valid);

  // Stage p0: output beat register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0 <= '0;
      sel_p0  <= '0;
      vld_p0  <= 1'b0;
      ptr     <= '0;
    end else if (xfer) begin
      data_p0 <= in_data[gidx*WIDTH +: WIDTH];
      sel_p0  <= gidx;
      vld_p0  <= 1'b1;
      if (MODE == MODE_RR && !force_en)
        ptr <= (int'(gidx) == NUM_IN - 1) ? '0 : gidx + SEL_W'(1);
    end else if (out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_data  = data_p0;
  assign out_sel   = sel_p0;
  assign out_valid = vld_p0;

endmodule
